sdram_dma_initiator: RTL and testbench

Wishbone initiator that drives the user project's DMA port into the SDRAM controller. It moves a programmed number of 32-bit words in one of two directions: from SDRAM to a valid/ready output stream through an internal FIFO, or from a valid/ready input stream into SDRAM. It sits beside the user project and owns the dma_wbs_* request wires that the project's DMA port receives.

---
 rtl/sdram_dma_initiator_if.sv | 21 ++
 rtl/sdram_dma_initiator.sv | 186 ++++++++++++++++++
 tb/tb_sdram_dma_initiator.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_dma_initiator_if.sv
// Wishbone request/response bundle between the DMA initiator and the SDRAM controller port.
interface sdram_dma_initiator_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        brust_valid_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, brust_valid_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, brust_valid_i
  );
endinterface

// File: rtl/sdram_dma_initiator.sv
// Wishbone DMA initiator moving LEN words between SDRAM and a valid/ready stream.
// Optional ack timeout is enabled by defining DMA_TIMEOUT_EN.
module sdram_dma_initiator #(
  parameter logic [8:0]  ADDR_PREFIX = 9'hF0,
  parameter int unsigned LEN_W       = 12,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_dir,
  input  logic [22:0]          cfg_base,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_W-1:0]     hit_cnt,
  sdram_dma_initiator_if.master wb,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StFetch, StReq, StDrain, StDone} state_e;

  state_e           state_q;
  logic             dir_q, cyc_q, stb_q, we_q, busy_q, done_q, err_q;
  logic [20:0]      word_q;
  logic [LEN_W-1:0] remain_q, hit_q;
  logic [31:0]      dat_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic ack_ok, push, pop;
  logic unused_base;

  assign unused_base = ^cfg_base[1:0];
  assign ack_ok      = (state_q == StReq) && stb_q && wb.wb_ack_i;
  assign push        = ack_ok && !dir_q;
  assign m_valid     = (cnt_q != '0);
  assign pop         = m_valid && m_ready;
  assign m_data      = mem_q[rd_ptr_q];
  assign s_ready     = (state_q == StFetch);

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = {ADDR_PREFIX, word_q, 2'b00};
  assign wb.wb_dat_o = dat_q;

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign hit_cnt = hit_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wb.wb_dat_i;
  end

`ifdef DMA_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= '0;
      remain_q <= '0;
      hit_q    <= '0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef DMA_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
`ifdef DMA_TIMEOUT_EN
      tmo_q <= (stb_q && !wb.wb_ack_i) ? tmo_q + 1'b1 : '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            dir_q    <= cfg_dir;
            word_q   <= cfg_base[22:2];
            remain_q <= cfg_len;
            err_q    <= 1'b0;
            hit_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            if (cfg_len == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (cfg_dir) begin
              busy_q  <= 1'b1;
              state_q <= StFetch;
            end else begin
              busy_q  <= 1'b1;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b0;
              state_q <= StReq;
            end
          end
        end
        StFetch: begin
          if (s_valid) begin
            dat_q   <= s_data;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (!stb_q) begin
            // Read-mode gap cycle: only issue when the FIFO can take the beat.
            if (cnt_q < CW'(FIFO_DEPTH)) begin
              cyc_q <= 1'b1;
              stb_q <= 1'b1;
              we_q  <= 1'b0;
            end
          end else if (wb.wb_ack_i) begin
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            word_q   <= word_q + 1'b1;
            remain_q <= remain_q - 1'b1;
            if (wb.brust_valid_i) hit_q <= hit_q + 1'b1;
            if (remain_q == LEN_W'(1)) begin
              if (dir_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StDone;
              end else begin
                state_q <= StDrain;
              end
            end else if (dir_q) begin
              state_q <= StFetch;
            end
          end
`ifdef DMA_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT - 1)) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
`endif
        end
        StDrain: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_dma_initiator.sv
// Scoreboard bench: memory-model slave, random stream source/sink, queue-based expectations.
module tb_sdram_dma_initiator;
  localparam int LW  = 12;
  localparam int TMO = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, cfg_dir;
  logic [22:0]   cfg_base;
  logic [LW-1:0] cfg_len;
  logic          busy, done, err;
  logic [LW-1:0] hit_cnt;
  logic [31:0]   m_data, s_data;
  logic          m_valid, m_ready, s_valid, s_ready;

  always #5 clk = ~clk;

  sdram_dma_initiator_if wb_if ();

  sdram_dma_initiator #(
    .ADDR_PREFIX(9'hF0), .LEN_W(LW), .FIFO_DEPTH(8), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .busy(busy), .done(done), .err(err), .hit_cnt(hit_cnt), .wb(wb_if),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  beat_t       exp_beat[$];
  logic [31:0] exp_rd[$];
  logic [31:0] src_q[$];
  int total = 0, bad = 0;
  int acks, hits, done_cnt = 0, cyc_seen = 0, d0, rmode = 2;
  bit ack_en = 1'b1;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Word address wraps within the 2^21-word SDRAM window; prefix 0xF0 lands at 0x7800_0000.
  function automatic logic [31:0] model_adr(logic [22:0] base, int i);
    int unsigned w;
    w = (32'(base) / 4 + i) % (1 << 21);
    return 32'h7800_0000 | (w * 4);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory-model slave: acks after 0..2 wait cycles, checks each accepted beat.
  initial begin
    int wcnt = 0, dly = 1;
    beat_t b;
    wb_if.wb_ack_i = 1'b0; wb_if.wb_dat_i = '0; wb_if.brust_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      wb_if.brust_valid_i = 1'($urandom_range(0, 1));
      if (rst) begin
        wb_if.wb_ack_i = 1'b0; wcnt = 0;
      end else if (wb_if.wb_ack_i) begin
        wb_if.wb_ack_i = 1'b0;
        check("stb_gap", wb_if.wb_stb_o, 0);
      end else if (wb_if.wb_stb_o && ack_en) begin
        if (wcnt >= dly) begin
          wb_if.wb_ack_i = 1'b1;
          wb_if.wb_dat_i = memf(wb_if.wb_adr_o);
          acks++;
          if (wb_if.brust_valid_i) hits++;
          wcnt = 0;
          dly  = $urandom_range(0, 2);
          check("beat_expected", 32'(exp_beat.size() != 0), 1);
          if (exp_beat.size() != 0) begin
            b = exp_beat.pop_front();
            check("adr", wb_if.wb_adr_o, b.adr);
            check("we", 32'(wb_if.wb_we_o), 32'(b.we));
            if (b.we) check("wdat", wb_if.wb_dat_o, b.dat);
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Sink: choose m_ready for the coming edge, then score the handshake that edge will take.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      if (!rst && m_valid && m_ready) begin
        check("word_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) check("m_data", m_data, exp_rd.pop_front());
      end
    end
  end

  // Source with random valid gaps.
  initial begin
    bit acc = 1'b0;
    s_valid = 1'b0; s_data = '0;
    forever begin
      @(negedge clk);
      if (acc) void'(src_q.pop_front());
      if (!rst && src_q.size() != 0 && $urandom_range(0, 2) != 0) begin
        s_valid = 1'b1; s_data = src_q[0];
      end else begin
        s_valid = 1'b0;
      end
      acc = s_valid && s_ready;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (wb_if.wb_cyc_o) cyc_seen++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic start_xfer(input bit dir, input logic [22:0] base, input int len);
    logic [31:0] a, d;
    @(negedge clk);
    hits = 0; acks = 0; d0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      a = model_adr(base, i);
      if (dir) begin
        d = $urandom;
        src_q.push_back(d);
        exp_beat.push_back('{adr: a, we: 1'b1, dat: d});
      end else begin
        exp_beat.push_back('{adr: a, we: 1'b0, dat: 32'h0});
        exp_rd.push_back(memf(a));
      end
    end
    cfg_dir = dir; cfg_base = base; cfg_len = LW'(len); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(len != 0));
    check("err_clear", 32'(err), 0);
    if (!dir) check("cyc_after_start", 32'(wb_if.wb_cyc_o), 32'(len != 0));
  endtask

  task automatic finish_xfer(input int len);
    int n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 1);
    check("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("done_count", 32'(done_cnt - d0), 1);
    check("ack_count", 32'(acks), 32'(len));
    check("hit_cnt", 32'(hit_cnt), 32'(hits));
    check("beats_left", 32'(exp_beat.size()), 0);
    check("words_left", 32'(exp_rd.size()), 0);
    check("src_left", 32'(src_q.size()), 0);
  endtask

  initial begin
    int c0, n;
    bit dir;
    int len;
    rst = 1'b1; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_base = '0; cfg_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cyc", 32'(wb_if.wb_cyc_o), 0);
    check("rst_stb", 32'(wb_if.wb_stb_o), 0);
    check("rst_adr", wb_if.wb_adr_o, 32'h7800_0000);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_hit", 32'(hit_cnt), 0);
    rst = 1'b0;

    rmode = 2;
    start_xfer(1'b0, 23'h100, 4); finish_xfer(4);
    start_xfer(1'b1, 23'h200, 3); finish_xfer(3);

    // Back-pressure: FIFO of 8 fills and requests stall until the sink drains.
    rmode = 0;
    start_xfer(1'b0, 23'h40, 12);
    repeat (60) @(negedge clk);
    check("bp_acks", 32'(acks), 8);
    check("bp_stb", 32'(wb_if.wb_stb_o), 0);
    rmode = 2;
    finish_xfer(12);

    c0 = cyc_seen;
    start_xfer(1'b1, 23'h10, 0); finish_xfer(0);
    check("len0_no_cyc", 32'(cyc_seen - c0), 0);

    start_xfer(1'b0, 23'h20, 2);
    repeat (2) @(negedge clk);
    cfg_len = LW'(9); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    finish_xfer(2);

    start_xfer(1'b0, 23'h7F_FFFC, 2); finish_xfer(2);
    start_xfer(1'b1, 23'h7F_FFF8, 3); finish_xfer(3);

    rmode = 1;
    for (int t = 0; t < 10; t++) begin
      dir = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 20);
      start_xfer(dir, 23'($urandom), len);
      finish_xfer(len);
    end
    rmode = 2;

`ifdef DMA_TIMEOUT_EN
    ack_en = 1'b0;
    @(negedge clk);
    cfg_dir = 1'b0; cfg_base = 23'h300; cfg_len = LW'(3); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    n = 0;
    while (wb_if.wb_stb_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_err", 32'(err), 1);
    check("tmo_done", 32'(done), 1);
    @(negedge clk);
    ack_en = 1'b1;
    start_xfer(1'b0, 23'h300, 1); finish_xfer(1);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
